// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per
// clock, LSB first, using a single borrow flip-flop. A start/done handshake
// lets the sequencer trade latency (WIDTH cycles) for area.
//
// Parameters
//   WIDTH  operand/result width, 2..16 (default 4)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts any operation)
//   start  request, sampled only in IDLE or DONE
//   a, b   minuend / subtrahend, sampled on the accepting edge
//   bin    borrow-in, sampled on the accepting edge
//   busy   high while bits are being shifted
//   done   one-cycle pulse when diff/bout/flags are valid
//   diff   result register, holds until the next completion
//   bout   final borrow-out, holds with diff
//   zero   diff == 0
//   neg    diff[WIDTH-1]
//   ovf    signed overflow
//
// Configuration
//   SERIAL_SUB_FLAGS_EN  when defined, zero/neg/ovf are computed and
//                        registered at completion; otherwise tied to 0.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;
    logic             last;

    // Full-subtractor borrow: borrow when x < y + bi.
    function automatic logic borrow_next(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        br_nxt  = borrow_next(sa[0], sb[0], br);
        // New bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
        res_nxt = {d, res[WIDTH-1:1]};
        accept  = start && ((state == IDLE) || (state == DONE));
        last    = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    res <= res_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff  <= res_nxt;
                        bout  <= br_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand MSBs are captured at accept because sa/sb are shifted away.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (last) begin
                zero <= (res_nxt == '0);
                neg  <= res_nxt[WIDTH-1];
                ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
            end
        end
    end
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;
`ifdef SERIAL_SUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, bout, zero, neg, ovf;
    logic [W-1:0] diff;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .zero (zero),
        .neg  (neg),
        .ovf  (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: result computed with integer arithmetic
    // at accept time, released WIDTH cycles later.
    int           left = 0;
    int           full, sa_i, sb_i, sres;
    bit           m_busy = 0, m_done = 0, m_bout = 0, m_z = 0, m_n = 0, m_o = 0;
    logic [W-1:0] m_diff = '0;
    bit           p_bout, p_z, p_n, p_o;
    logic [W-1:0] p_diff;

    always @(posedge clk) begin
        if (rst) begin
            left = 0; m_busy = 0; m_done = 0; m_diff = '0;
            m_bout = 0; m_z = 0; m_n = 0; m_o = 0;
        end else begin
            m_done = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_diff = p_diff; m_bout = p_bout;
                    m_z = p_z; m_n = p_n; m_o = p_o;
                end
            end else if (start) begin
                full   = int'(a) - int'(b) - int'(bin);
                p_diff = full[W-1:0];
                p_bout = (full < 0);
                sa_i   = a[W-1] ? int'(a) - (1 << W) : int'(a);
                sb_i   = b[W-1] ? int'(b) - (1 << W) : int'(b);
                sres   = sa_i - sb_i - int'(bin);
                p_z    = FL && (p_diff == '0);
                p_n    = FL && p_diff[W-1];
                p_o    = FL && ((sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1));
                left   = W;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("bout", 32'(bout), 32'(m_bout));
            chk("zero", 32'(zero), 32'(m_z));
            chk("neg",  32'(neg),  32'(m_n));
            chk("ovf",  32'(ovf),  32'(m_o));
        end
    end

    // Called at a negedge; launches a request and waits for done.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] ed, input bit eb, input bit ez, input bit en,
                      input bit eo, input bit mid, input string nm);
        int cyc;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mid && cyc == 1) begin
                start = 1'b1; a = 1; b = 1; bin = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd4);
        chk({nm, "_diff"},    32'(diff), 32'(ed));
        chk({nm, "_bout"},    32'(bout), 32'(eb));
        chk({nm, "_zero"},    32'(zero), 32'(ez & FL));
        chk({nm, "_neg"},     32'(neg),  32'(en & FL));
        chk({nm, "_ovf"},     32'(ovf),  32'(eo & FL));
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", {29'd0, zero, neg, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op(4'd7, 4'd3, 1'b0, 4'd4,  0, 0, 0, 0, 0, "t1");
        @(negedge clk);
        op(4'd3, 4'd5, 1'b0, 4'd14, 1, 0, 1, 0, 0, "t2a");
        op(4'd0, 4'd0, 1'b1, 4'd15, 1, 0, 1, 0, 0, "t2b");
        @(negedge clk);
        op(4'd8, 4'd1, 1'b0, 4'd7,  0, 0, 0, 1, 0, "t3a");
        @(negedge clk);
        op(4'd5, 4'd5, 1'b0, 4'd0,  0, 1, 0, 0, 0, "t3b");
        @(negedge clk);
        // Mid-shift start ignored, then back-to-back from the DONE cycle.
        op(4'd9, 4'd2, 1'b0, 4'd7,  0, 0, 0, 1, 1, "t4a");
        op(4'd4, 4'd1, 1'b0, 4'd3,  0, 0, 0, 0, 0, "t4b");
        @(negedge clk);

        // Reset during the second shift cycle aborts the operation.
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_diff", 32'(diff), 32'd0);
        chk("t5_bout", 32'(bout), 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        op(4'd6, 4'd1, 1'b0, 4'd5, 0, 0, 0, 0, 0, "t5b");

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 80) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
